// File: rtl/sys_skew_feeder.sv
// Buffers one MxM A and one MxM B from a serial beat stream, then drives skewed wavefronts onto the array edges.
// Load takes M*M accepted beats. Feed starts right after the last beat and runs 3M-2 accepted steps. arr_rdy low holds the wavefront.
module sys_skew_feeder #(
  parameter int M  = 3,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic          arr_vld,
  input  logic          arr_rdy,
  output logic [M*DW-1:0] arr_a,
  output logic [M*DW-1:0] arr_b,
  output logic          arr_first,
  output logic          arr_last
);

  localparam int NW = $clog2(M*M);
  localparam int TW = $clog2(3*M-2);
  localparam int KW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic {LOAD, FEED} state_t;

  state_t          state;
  logic [NW-1:0]   n;
  logic [TW-1:0]   t;
  logic            rdy_q;
  logic [DW-1:0]   a_buf [M][M];
  logic [DW-1:0]   b_buf [M][M];
  logic [KW-1:0]   k_idx;
  logic [KW-1:0]   x_idx;
  logic            load_acc;
  logic            feed_acc;

  // Beat n carries column k of A and row k of B, element x.
  always_comb begin
    k_idx = KW'(32'(n) / M);
    x_idx = KW'(32'(n) % M);
  end

  assign load_acc = in_vld && rdy_q;
  assign feed_acc = (state == FEED) && arr_rdy;
  assign in_rdy   = rdy_q;
  assign arr_vld  = (state == FEED);

  always_ff @(posedge CLK) begin
    if (rst) begin
      state <= LOAD;
      n     <= '0;
      t     <= '0;
      rdy_q <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          rdy_q <= 1'b1;
          if (load_acc) begin
            a_buf[x_idx][k_idx] <= a_in;
            b_buf[k_idx][x_idx] <= b_in;
            if (n == NW'(M*M-1)) begin
              n     <= '0;
              t     <= '0;
              state <= FEED;
              rdy_q <= 1'b0;
            end else begin
              n <= n + 1'b1;
            end
          end
        end
        FEED: begin
          rdy_q <= 1'b0;
          if (feed_acc) begin
            if (t == TW'(3*M-3)) begin
              t     <= '0;
              state <= LOAD;
              rdy_q <= 1'b1;
            end else begin
              t <= t + 1'b1;
            end
          end
        end
        default: begin
          state <= LOAD;
          rdy_q <= 1'b0;
        end
      endcase
    end
  end

  // Lane i sees element k of its row/column when t == i + k; outside that window the lane is zero.
  always_comb begin
    arr_a = '0;
    arr_b = '0;
    if (state == FEED) begin
      for (int i = 0; i < M; i++) begin
        for (int k = 0; k < M; k++) begin
          if (t == TW'(i + k)) begin
            arr_a[i*DW +: DW] = a_buf[i][k];
            arr_b[i*DW +: DW] = b_buf[k][i];
          end
        end
      end
    end
  end

  assign arr_first = (state == FEED) && (t == '0);
  assign arr_last  = (state == FEED) && (t == TW'(3*M-3));

endmodule

// File: tb/tb_sys_skew_feeder.sv
// Directed bench for sys_skew_feeder (M=3, DW=8): table-driven wavefront checks plus stall, gap and reset sequences.
module tb_sys_skew_feeder;

  localparam int M  = 3;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          rst;
  logic          in_vld;
  logic          in_rdy;
  logic [DW-1:0] a_in;
  logic [DW-1:0] b_in;
  logic          arr_vld;
  logic          arr_rdy;
  logic [M*DW-1:0] arr_a;
  logic [M*DW-1:0] arr_b;
  logic          arr_first;
  logic          arr_last;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic        first;
    logic        last;
  } vec_t;

  vec_t vec [14];
  int   ma [3][3];
  int   mb [3][3];

  sys_skew_feeder #(.M(M), .DW(DW)) dut (
    .CLK(CLK), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy),
    .a_in(a_in), .b_in(b_in), .arr_vld(arr_vld), .arr_rdy(arr_rdy),
    .arr_a(arr_a), .arr_b(arr_b), .arr_first(arr_first), .arr_last(arr_last)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic set_test2();
    ma = '{'{1,1,0}, '{0,1,0}, '{0,1,1}};
    mb = '{'{1,0,0}, '{0,2,0}, '{2,0,1}};
  endtask

  task automatic set_ident();
    ma = '{'{1,0,0}, '{0,1,0}, '{0,0,1}};
    mb = '{'{1,0,0}, '{0,1,0}, '{0,0,1}};
  endtask

  // Called at a negedge; returns at the negedge right after the last beat is accepted.
  task automatic load(input bit gap);
    for (int n = 0; n < M*M; n++) begin
      if (gap) begin
        in_vld = 1'b0;
        a_in   = 8'($urandom);
        b_in   = 8'($urandom);
        cyc();
      end
      chk("load_in_rdy", 32'(in_rdy), 32'd1);
      chk("load_arr_vld", 32'(arr_vld), 32'd0);
      in_vld = 1'b1;
      a_in   = 8'(ma[n % M][n / M]);
      b_in   = 8'(mb[n / M][n % M]);
      cyc();
      in_vld = 1'b0;
    end
  endtask

  task automatic feed(input int base, input int stall_at, input int rst_at, input bit garbage);
    if (garbage) begin
      in_vld = 1'b1;
      a_in   = 8'hee;
      b_in   = 8'hdd;
    end
    for (int s = 0; s < 3*M-2; s++) begin
      chk("feed_vld", 32'(arr_vld), 32'd1);
      chk("feed_in_rdy", 32'(in_rdy), 32'd0);
      chk("feed_a", 32'(arr_a), 32'(vec[base+s].a));
      chk("feed_b", 32'(arr_b), 32'(vec[base+s].b));
      chk("feed_first", 32'(arr_first), 32'(vec[base+s].first));
      chk("feed_last", 32'(arr_last), 32'(vec[base+s].last));
      if (s == rst_at) begin
        rst = 1'b1;
        cyc();
        chk("rst_arr_vld", 32'(arr_vld), 32'd0);
        chk("rst_in_rdy", 32'(in_rdy), 32'd0);
        chk("rst_arr_a", 32'(arr_a), 32'd0);
        rst = 1'b0;
        cyc();
        chk("rst_rel_in_rdy", 32'(in_rdy), 32'd1);
        return;
      end
      if (s == stall_at) begin
        arr_rdy = 1'b0;
        for (int h = 0; h < 4; h++) begin
          cyc();
          chk("stall_vld", 32'(arr_vld), 32'd1);
          chk("stall_a", 32'(arr_a), 32'(vec[base+s].a));
          chk("stall_b", 32'(arr_b), 32'(vec[base+s].b));
          chk("stall_first", 32'(arr_first), 32'(vec[base+s].first));
        end
        arr_rdy = 1'b1;
      end
      cyc();
    end
    in_vld = 1'b0;
    chk("post_arr_vld", 32'(arr_vld), 32'd0);
    chk("post_in_rdy", 32'(in_rdy), 32'd1);
    chk("post_arr_a", 32'(arr_a), 32'd0);
    chk("post_last", 32'(arr_last), 32'd0);
  endtask

  initial begin
    // Lanes packed {lane2, lane1, lane0}. Entries 0..6: test-2 matrices; 7..13: identity.
    vec[0]  = '{a:24'h000001, b:24'h000001, first:1'b1, last:1'b0};
    vec[1]  = '{a:24'h000001, b:24'h000000, first:1'b0, last:1'b0};
    vec[2]  = '{a:24'h000100, b:24'h000202, first:1'b0, last:1'b0};
    vec[3]  = '{a:24'h010000, b:24'h000000, first:1'b0, last:1'b0};
    vec[4]  = '{a:24'h010000, b:24'h010000, first:1'b0, last:1'b0};
    vec[5]  = '{a:24'h000000, b:24'h000000, first:1'b0, last:1'b0};
    vec[6]  = '{a:24'h000000, b:24'h000000, first:1'b0, last:1'b1};
    vec[7]  = '{a:24'h000001, b:24'h000001, first:1'b1, last:1'b0};
    vec[8]  = '{a:24'h000000, b:24'h000000, first:1'b0, last:1'b0};
    vec[9]  = '{a:24'h000100, b:24'h000100, first:1'b0, last:1'b0};
    vec[10] = '{a:24'h000000, b:24'h000000, first:1'b0, last:1'b0};
    vec[11] = '{a:24'h010000, b:24'h010000, first:1'b0, last:1'b0};
    vec[12] = '{a:24'h000000, b:24'h000000, first:1'b0, last:1'b0};
    vec[13] = '{a:24'h000000, b:24'h000000, first:1'b0, last:1'b1};

    rst     = 1'b1;
    in_vld  = 1'b1;
    a_in    = 8'h55;
    b_in    = 8'h66;
    arr_rdy = 1'b1;
    @(negedge CLK);

    // Reset held with in_vld high: nothing accepted, nothing fed.
    for (int r = 0; r < 3; r++) begin
      cyc();
      chk("reset_in_rdy", 32'(in_rdy), 32'd0);
      chk("reset_arr_vld", 32'(arr_vld), 32'd0);
      chk("reset_arr_a", 32'(arr_a), 32'd0);
      chk("reset_arr_b", 32'(arr_b), 32'd0);
      chk("reset_first", 32'(arr_first), 32'd0);
      chk("reset_last", 32'(arr_last), 32'd0);
    end
    rst    = 1'b0;
    in_vld = 1'b0;
    cyc();
    chk("reset_release_in_rdy", 32'(in_rdy), 32'd1);
    chk("reset_release_arr_vld", 32'(arr_vld), 32'd0);

    set_test2();
    load(1'b0);
    feed(0, -1, -1, 1'b0);

    set_ident();
    load(1'b0);
    feed(7, -1, -1, 1'b0);

    set_test2();
    load(1'b0);
    feed(0, 2, -1, 1'b0);

    // Gapped load, then upstream keeps in_vld high through the feed.
    set_ident();
    load(1'b1);
    feed(7, -1, -1, 1'b1);
    set_test2();
    load(1'b0);
    feed(0, -1, -1, 1'b0);

    // Reset mid-feed, then a fresh load must feed its own data.
    set_test2();
    load(1'b0);
    feed(0, -1, 3, 1'b0);
    set_ident();
    load(1'b0);
    feed(7, -1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
